// File: rtl/mvm_job_sequencer.sv
// mvm_job_sequencer: stages host operands, replays them to an mvm engine as gap-free bursts and returns its results
//   clk, reset                  : clock and synchronous active-high reset
//   cmd_valid/ready, cmd_mode   : job command (11 mat+vec, 10 mat, 01 vec, 00 start only)
//   in_valid/ready, in_data     : operand word stream
//   out_valid/ready, out_data,
//   out_last                    : result word stream, last marks word K-1
//   busy, err_timeout           : not idle; sticky done-timeout flag
//   mvm_*                       : engine load/start pulses, operand out, done and result in
module mvm_job_sequencer #(
    parameter int K       = 8,
    parameter int B       = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [B-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [2*B-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  err_timeout,
    output logic                  mvm_loadMatrix,
    output logic                  mvm_loadVector,
    output logic                  mvm_start,
    output logic signed [B-1:0]   mvm_data_in,
    input  logic                  mvm_done,
    input  logic signed [2*B-1:0] mvm_data_out
);
    localparam int KK = K * K;
    localparam int CW = $clog2(KK + 1);
    localparam int AW = $clog2(KK);
    localparam int RW = $clog2(K);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, FILL, BURST, START, WAIT_DONE, CAPTURE} state_t;
    state_t                 state_q;
    logic [1:0]             mode_q;
    logic                   tgt_q;
    logic [CW-1:0]          n_q, cnt_q;
    logic [TW-1:0]          tmr_q;
    logic                   done_q, err_q, full_q;
    logic [RW-1:0]          rd_q;
    logic                   cmd_ready_q, in_ready_q, lm_q, lv_q, st_q;
    logic signed [B-1:0]    din_q;
    logic signed [B-1:0]    sbuf [KK];
    logic signed [2*B-1:0]  obuf [K];
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            tgt_q       <= 1'b0;
            n_q         <= '0;
            cnt_q       <= '0;
            tmr_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            full_q      <= 1'b0;
            rd_q        <= '0;
            cmd_ready_q <= 1'b0;
            in_ready_q  <= 1'b0;
            lm_q        <= 1'b0;
            lv_q        <= 1'b0;
            st_q        <= 1'b0;
            din_q       <= '0;
        end else begin
            lm_q   <= 1'b0;
            lv_q   <= 1'b0;
            st_q   <= 1'b0;
            din_q  <= '0;
            done_q <= mvm_done;
            // result drain runs independently of the job FSM
            if (full_q && out_ready) begin
                if (rd_q == RW'(K - 1)) begin
                    full_q <= 1'b0;
                    rd_q   <= '0;
                end else begin
                    rd_q <= rd_q + RW'(1);
                end
            end
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        mode_q      <= cmd_mode;
                        cmd_ready_q <= 1'b0;
                        tgt_q       <= cmd_mode[1];
                        n_q         <= cmd_mode[1] ? CW'(KK) : CW'(K);
                        in_ready_q  <= cmd_mode != 2'b00;
                        state_q     <= cmd_mode == 2'b00 ? START : FILL;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                FILL: begin
                    if (in_valid && in_ready_q) begin
                        sbuf[cnt_q[AW-1:0]] <= in_data;
                        if (cnt_q == n_q - CW'(1)) begin
                            cnt_q      <= '0;
                            in_ready_q <= 1'b0;
                            lm_q       <= tgt_q;
                            lv_q       <= !tgt_q;
                            state_q    <= BURST;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                BURST: begin
                    if (cnt_q != n_q) begin
                        din_q <= sbuf[cnt_q[AW-1:0]];
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        cnt_q <= '0;
                        if (mode_q == 2'b11 && tgt_q) begin
                            tgt_q      <= 1'b0;
                            n_q        <= CW'(K);
                            in_ready_q <= 1'b1;
                            state_q    <= FILL;
                        end else begin
                            state_q <= START;
                        end
                    end
                end
                START: begin
                    if (!full_q) begin
                        st_q    <= 1'b1;
                        tmr_q   <= TW'(TIMEOUT - 1);
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // done_q tracks the level continuously, so a level already high is never an edge
                    if (mvm_done && !done_q) begin
                        state_q <= CAPTURE;
                    end else if (tmr_q == '0) begin
                        err_q       <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                CAPTURE: begin
                    obuf[cnt_q[RW-1:0]] <= mvm_data_out;
                    if (cnt_q == CW'(K - 1)) begin
                        cnt_q       <= '0;
                        full_q      <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign cmd_ready      = cmd_ready_q;
    assign in_ready       = in_ready_q;
    assign out_valid      = full_q;
    assign out_data       = full_q ? obuf[rd_q] : '0;
    assign out_last       = full_q && rd_q == RW'(K - 1);
    assign busy           = state_q != IDLE;
    assign err_timeout    = err_q;
    assign mvm_loadMatrix = lm_q;
    assign mvm_loadVector = lv_q;
    assign mvm_start      = st_q;
    assign mvm_data_in    = din_q;
endmodule

// File: tb/tb_mvm_job_sequencer.sv
// tb_mvm_job_sequencer: scoreboard bench with a behavioural engine for mvm_job_sequencer
module tb_mvm_job_sequencer;
    logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [1:0] cmd_mode = 2'b00;
    logic signed [7:0] in_data = '0;
    logic cmd_ready, in_ready, out_valid, out_last, busy, err_timeout;
    logic mvm_loadMatrix, mvm_loadVector, mvm_start;
    logic mvm_done = 1'b0;
    logic signed [15:0] out_data;
    logic signed [15:0] mvm_data_out = '0;
    logic signed [7:0] mvm_data_in;

    int n_cmp = 0, n_err = 0, n_start = 0, start_cyc = 0, cyc = 0, eng_mode = 0, nw = 0;
    logic signed [7:0] op_q[$];
    bit pulse_q[$];
    logic [16:0] out_q[$];
    logic signed [7:0] words[72];
    logic signed [7:0] vec_a[8];
    logic signed [15:0] exp_a[8];

    mvm_job_sequencer #(.K(8), .B(8), .TIMEOUT(4096)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err_timeout(err_timeout),
        .mvm_loadMatrix(mvm_loadMatrix), .mvm_loadVector(mvm_loadVector), .mvm_start(mvm_start),
        .mvm_data_in(mvm_data_in), .mvm_done(mvm_done), .mvm_data_out(mvm_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s", nm);
    endtask

    // engine stand-in: records loaded operands, checks them against the operand scoreboard,
    // and answers a start with done plus K result words
    initial begin
        int ld_left = 0, ld_idx = 0, e_cnt = -1;
        bit ld_m = 0;
        logic signed [7:0] m[64];
        logic signed [7:0] v[8];
        int res[8];
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                ld_left = 0;
                e_cnt = -1;
                mvm_done = 1'b0;
                continue;
            end
            if (ld_left > 0) begin
                if (op_q.size() == 0) fail("op_unexpected_word");
                else chk("op_word", mvm_data_in, op_q.pop_front());
                if (mvm_loadMatrix || mvm_loadVector) fail("pulse_inside_burst");
                if (ld_m) m[ld_idx] = mvm_data_in; else v[ld_idx] = mvm_data_in;
                ld_idx++;
                ld_left--;
            end else begin
                chk("din_idle_zero", mvm_data_in, 0);
                if (mvm_loadMatrix || mvm_loadVector) begin
                    chk("pulse_one_target", mvm_loadMatrix && mvm_loadVector, 0);
                    if (pulse_q.size() == 0) fail("pulse_unexpected");
                    else chk("pulse_kind_matrix", mvm_loadMatrix, pulse_q.pop_front());
                    ld_m = mvm_loadMatrix;
                    ld_left = ld_m ? 64 : 8;
                    ld_idx = 0;
                end
            end
            if (mvm_start) begin
                n_start++;
                start_cyc = cyc;
                chk("start_with_obuf_empty", out_valid, 0);
                for (int i = 0; i < 8; i++) begin
                    res[i] = 0;
                    for (int j = 0; j < 8; j++) res[i] += int'(m[i*8+j]) * int'(v[j]);
                end
                e_cnt = 0;
                mvm_done = 1'b0;
            end else if (e_cnt >= 0) begin
                e_cnt++;
                if (eng_mode == 0 && e_cnt == 4) mvm_done = 1'b1;
                if (eng_mode == 0 && e_cnt >= 5 && e_cnt < 13) mvm_data_out = 16'(res[e_cnt-5]);
                if (e_cnt == 13) e_cnt = -1;
            end
            if (eng_mode == 1) mvm_done = 1'b0;
            if (eng_mode == 2) mvm_done = 1'b1;
        end
    end

    // output monitor: pops the result scoreboard on every handshake
    logic signed [15:0] prev_d = '0;
    bit prev_hold = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                chk("out_valid_held", out_valid, 1);
                chk("out_data_held", out_data, prev_d);
            end
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) fail("out_unexpected_word");
                else begin
                    logic [16:0] e;
                    e = out_q.pop_front();
                    chk("out_data", out_data, $signed(e[15:0]));
                    chk("out_last", out_last, e[16]);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_d = out_data;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic [1:0] md);
        bit acc = 0;
        int t = 0;
        cmd_mode = md;
        cmd_valid = 1'b1;
        while (!acc && t < 10000) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk); #1;
            t++;
        end
        cmd_valid = 1'b0;
        chk("cmd_accepted", acc, 1);
    endtask

    task automatic send_words(input int n, input bit stall);
        int i = 0, t = 0;
        bit acc;
        while (i < n && t < 20000) begin
            in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data = words[i];
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            t++;
        end
        in_valid = 1'b0;
        chk("words_accepted", i, n);
    endtask

    task automatic prep(input logic [1:0] md, input int diag);
        nw = 0;
        if (md[1]) begin
            pulse_q.push_back(1'b1);
            for (int i = 0; i < 64; i++) begin
                words[nw] = (i / 8 == i % 8) ? 8'(diag) : 8'sd0;
                op_q.push_back(words[nw]);
                nw++;
            end
        end
        if (md[0]) begin
            pulse_q.push_back(1'b0);
            for (int i = 0; i < 8; i++) begin
                words[nw] = vec_a[i];
                op_q.push_back(vec_a[i]);
                nw++;
            end
        end
    endtask

    task automatic push_exp();
        for (int i = 0; i < 8; i++) out_q.push_back({i == 7, exp_a[i]});
    endtask

    task automatic wait_drain(input string nm);
        int t = 0;
        while ((out_q.size() != 0 || busy || out_valid) && t < 20000) begin
            @(posedge clk); #1;
            t++;
        end
        chk({nm, "_drained_in_budget"}, t < 20000, 1);
    endtask

    task automatic check_zero(input string p);
        @(negedge clk);
        chk({p, "_ctrl_outputs"}, {cmd_ready, in_ready, out_valid, out_last, busy, err_timeout,
            mvm_loadMatrix, mvm_loadVector, mvm_start}, 0);
        chk({p, "_mvm_data_in"}, mvm_data_in, 0);
        chk({p, "_out_data"}, out_data, 0);
    endtask

    task automatic timeout_run(input string nm);
        int t = 0, s0;
        s0 = n_start;
        send_cmd(2'b00);
        while (busy && t < 6000) begin
            @(posedge clk); #1;
            t++;
        end
        chk({nm, "_one_start"}, n_start, s0 + 1);
        chk({nm, "_cycles"}, cyc - start_cyc, 4096);
        chk({nm, "_err"}, err_timeout, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk({nm, "_no_output"}, out_valid, 0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int s0, t;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // identity matrix, vector 1..8, no stalls
        for (int i = 0; i < 8; i++) begin vec_a[i] = 8'(i + 1); exp_a[i] = 16'(i + 1); end
        prep(2'b11, 1);
        push_exp();
        send_cmd(2'b11);
        send_words(nw, 1'b0);
        wait_drain("m11");
        chk("m11_starts", n_start, 1);

        // same job with in_valid toggling
        prep(2'b11, 1);
        push_exp();
        send_cmd(2'b11);
        send_words(nw, 1'b1);
        wait_drain("m11_stall");
        chk("m11_stall_starts", n_start, 2);

        // vector only, identity matrix retained
        for (int i = 0; i < 8; i++) begin vec_a[i] = 8'sd2; exp_a[i] = 16'sd2; end
        prep(2'b01, 1);
        push_exp();
        send_cmd(2'b01);
        send_words(nw, 1'b0);
        wait_drain("m01");
        chk("m01_starts", n_start, 3);

        // start-only job blocked behind undrained results
        for (int i = 0; i < 8; i++) begin vec_a[i] = 8'sd3; exp_a[i] = 16'sd3; end
        out_ready = 1'b0;
        prep(2'b01, 1);
        push_exp();
        send_cmd(2'b01);
        send_words(nw, 1'b0);
        t = 0;
        while (!out_valid && t < 2000) begin @(posedge clk); #1; t++; end
        chk("m00_results_ready", out_valid, 1);
        push_exp();
        s0 = n_start;
        send_cmd(2'b00);
        repeat (50) @(posedge clk);
        #1;
        chk("m00_start_held", n_start, s0);
        chk("m00_busy_in_start", busy, 1);
        chk("m00_head_word", out_data, 3);
        out_ready = 1'b1;
        wait_drain("m00");
        chk("m00_start_once", n_start, s0 + 1);

        // done never rises, then done stuck high
        chk("err_clear_before", err_timeout, 0);
        eng_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        timeout_run("to_low");
        eng_mode = 2;
        repeat (5) @(posedge clk);
        #1;
        timeout_run("to_high");
        eng_mode = 0;

        // reset in burst cycle 30 of the matrix
        for (int i = 0; i < 8; i++) vec_a[i] = 8'(i + 1);
        prep(2'b11, 1);
        send_cmd(2'b11);
        send_words(64, 1'b0);
        t = 0;
        while (!mvm_loadMatrix && t < 100) begin @(posedge clk); #1; t++; end
        chk("rst_burst_seen", mvm_loadMatrix, 1);
        repeat (30) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_zero("mid_burst_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        op_q.delete();
        pulse_q.delete();
        @(posedge clk); #1;

        // fresh signed job: 2*I times -1..-8
        for (int i = 0; i < 8; i++) begin vec_a[i] = 8'(-(i + 1)); exp_a[i] = 16'(-2 * (i + 1)); end
        prep(2'b11, 2);
        push_exp();
        send_cmd(2'b11);
        send_words(nw, 1'b0);
        wait_drain("after_reset");
        chk("after_reset_err", err_timeout, 0);

        chk("op_queue_empty", op_q.size(), 0);
        chk("pulse_queue_empty", pulse_q.size(), 0);
        chk("out_queue_empty", out_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
